cpu_controller: RTL
===================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Instr, input, 32, current instruction from ROM.
REQ-004 SHALL have port ALUFlags, input, 4, datapath flags {N,Z,C,V} (bit3=N ... bit0=V).
REQ-005 SHALL have port MemReady, input, 1, data memory completion strobe.
REQ-006 SHALL have outputs RegSrc[1:0], RegWrite, ImmSrc[1:0], ALUSrc, ALUControl[3:0], MemToReg, PCSrc with the datapath meanings.
REQ-007 SHALL have outputs MemWrite (1), MemReq (1), PCWrite (1, PC register enable) and MemErr (1, sticky timeout error).

Function
REQ-008 SHALL decode op=Instr[27:26]: 00 data-processing (DP), 01 memory (MEM), 10 branch (B); 11 is a NOP.
REQ-009 SHALL hold a 4-bit flag register; CondEx is the ARM evaluation of Instr[31:28] against it; 1110 is always true; 1111 is always false.
REQ-010 SHALL drive ImmSrc: DP 00, MEM 01, B 10; ALUSrc: DP = Instr[25], MEM/B = 1.
REQ-011 SHALL drive RegSrc[0]=1 for B only; RegSrc[1]=1 for STR (MEM with Instr[20]=0) only; MemToReg=1 for LDR only.
REQ-012 SHALL drive ALUControl: DP cmd Instr[24:21] 0100->0000 ADD, 0010->0001 SUB, 0000->0010 AND, 1100->0011 ORR, 1010 (CMP)->0001; MEM: Instr[23]=1 ADD, else SUB; B: ADD.
REQ-013 SHALL treat any other DP cmd as a NOP: no register write, no flag update.
REQ-014 SHALL implement an FSM with states RUN and MEMWAIT.
REQ-015 In RUN with DP/B/NOP or CondEx=0: SHALL assert PCWrite=1 for that single cycle and remain in RUN.
REQ-016 DP in RUN with CondEx=1: RegWrite=1 except CMP; if Instr[20]=1, the flag register loads ALUFlags at the clock edge.
REQ-017 SHALL assert PCSrc=CondEx for B, and for DP writes with Rd=Instr[15:12]=1111.
REQ-018 MEM in RUN with CondEx=1: SHALL assert MemReq=1 and MemWrite=1 (STR), hold PCWrite=0 and RegWrite=0, and enter MEMWAIT.
REQ-019 In MEMWAIT: SHALL keep MemReq and MemWrite stable and PCWrite=0 while MemReady=0.
REQ-020 In MEMWAIT when MemReady=1: same cycle SHALL assert PCWrite=1 and RegWrite=1 (LDR); then return to RUN.
REQ-021 SHALL ignore MemReady=1 sampled in RUN (no early completion).
REQ-022 SHALL never update flags for MEM or B instructions.

Reset
REQ-023 While reset=1: SHALL force state=RUN, flags=0000, MemErr=0, timeout counter=0.
REQ-024 While reset=1: SHALL force RegWrite, MemWrite, MemReq, PCWrite and PCSrc to 0 combinationally, including mid-MEMWAIT.

Configuration
REQ-025 Macro CTRL_MEM_TIMEOUT_EN defined: a 4-bit counter SHALL count MEMWAIT cycles.
REQ-026 With the macro, on the 16th MEMWAIT cycle without MemReady: SHALL assert PCWrite=1 with RegWrite=0, set MemErr=1 (sticky until reset) and return to RUN.
REQ-027 With the macro, MemReady=1 on the 16th cycle SHALL take priority: normal completion, MemErr unchanged.
REQ-028 Macro undefined: SHALL wait in MEMWAIT indefinitely and tie MemErr to 0.

Verification
REQ-029 ADDS R1,R2,#1 (0xE2921001) with ALUFlags=0100 -> RegWrite=1, PCWrite=1, ALUControl=0000, ALUSrc=1; next cycle flags=0100.
REQ-030 BEQ (cond 0000) with flags Z=1 -> PCSrc=1, PCWrite=1; with flags 0000 -> PCSrc=0, RegWrite=0, PCWrite=1.
REQ-031 LDR (0xE5921000), MemReady low 3 cycles then high -> MemReq=1 for 4 cycles; PCWrite=0 for 3 cycles; RegWrite=1, MemToReg=1, PCWrite=1 on the 4th cycle.
REQ-032 STR held in MEMWAIT, reset asserted on 2nd wait cycle -> MemReq=MemWrite=PCWrite=0 immediately; state=RUN after the edge.
REQ-033 Undefined DP cmd 0xE1A00000 pattern with S=1 -> RegWrite=0, flags unchanged, PCWrite=1.
REQ-034 With CTRL_MEM_TIMEOUT_EN, LDR with MemReady held 0 -> on 16th wait cycle PCWrite=1, RegWrite=0; MemErr=1 thereafter until reset.

Source files
------------

// File: rtl/cpu_controller.sv
// ============================================================================
// Module  : cpu_controller
// Purpose : Single-issue ARM-subset control unit with a RUN/MEMWAIT handshake FSM.
//           Optional memory timeout enabled by defining CTRL_MEM_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUControl,
  output logic        MemToReg,
  output logic        PCSrc,
  output logic        MemWrite,
  output logic        MemReq,
  output logic        PCWrite,
  output logic        MemErr
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_flags;
  logic       w_cond_ex;
  logic       w_flag_wr;
  logic       w_is_dp;
  logic       w_is_mem;
  logic       w_is_b;
  logic       w_is_cmp;
  logic       w_cmd_valid;
  logic       w_timeout;
  logic       w_unused;

  assign w_is_dp  = (Instr[27:26] == 2'b00);
  assign w_is_mem = (Instr[27:26] == 2'b01);
  assign w_is_b   = (Instr[27:26] == 2'b10);
  assign w_is_cmp = (Instr[24:21] == 4'b1010);
  assign w_unused = ^{Instr[22], Instr[19:16], Instr[11:0]};

  // Condition evaluation against the stored flags {N,Z,C,V}
  always_comb begin
    w_cond_ex = 1'b0;
    case (Instr[31:28])
      4'b0000: w_cond_ex = r_flags[2];
      4'b0001: w_cond_ex = ~r_flags[2];
      4'b0010: w_cond_ex = r_flags[1];
      4'b0011: w_cond_ex = ~r_flags[1];
      4'b0100: w_cond_ex = r_flags[3];
      4'b0101: w_cond_ex = ~r_flags[3];
      4'b0110: w_cond_ex = r_flags[0];
      4'b0111: w_cond_ex = ~r_flags[0];
      4'b1000: w_cond_ex = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_ex = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
      4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
      4'b1100: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Datapath steering decode
  always_comb begin
    ImmSrc      = 2'b00;
    ALUSrc      = 1'b0;
    RegSrc      = 2'b00;
    MemToReg    = 1'b0;
    ALUControl  = 4'b0000;
    w_cmd_valid = 1'b0;
    if (w_is_dp) begin
      ALUSrc      = Instr[25];
      w_cmd_valid = 1'b1;
      case (Instr[24:21])
        4'b0100: ALUControl = 4'b0000;
        4'b0010: ALUControl = 4'b0001;
        4'b0000: ALUControl = 4'b0010;
        4'b1100: ALUControl = 4'b0011;
        4'b1010: ALUControl = 4'b0001;
        default: w_cmd_valid = 1'b0;
      endcase
    end else if (w_is_mem) begin
      ImmSrc     = 2'b01;
      ALUSrc     = 1'b1;
      RegSrc[1]  = ~Instr[20];
      MemToReg   = Instr[20];
      ALUControl = Instr[23] ? 4'b0000 : 4'b0001;
    end else if (w_is_b) begin
      ImmSrc    = 2'b10;
      ALUSrc    = 1'b1;
      RegSrc[0] = 1'b1;
    end
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [3:0] r_tmo_cnt;
  logic       r_mem_err;
`endif

  // Next-state and strobes; reset masks every strobe combinationally
  always_comb begin
    w_next_state = r_state;
    RegWrite     = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    w_flag_wr    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_is_mem && w_cond_ex) begin
          MemReq       = 1'b1;
          MemWrite     = ~Instr[20];
          w_next_state = MEMWAIT;
        end else begin
          PCWrite = 1'b1;
          if (w_is_dp && w_cond_ex && w_cmd_valid) begin
            RegWrite  = ~w_is_cmp;
            w_flag_wr = Instr[20];
            PCSrc     = ~w_is_cmp && (Instr[15:12] == 4'hF);
          end
          if (w_is_b) PCSrc = w_cond_ex;
        end
      end
      MEMWAIT: begin
        MemReq   = 1'b1;
        MemWrite = ~Instr[20];
        if (MemReady) begin
          PCWrite      = 1'b1;
          RegWrite     = Instr[20];
          w_next_state = RUN;
        end
`ifdef CTRL_MEM_TIMEOUT_EN
        else if (r_tmo_cnt == 4'hF) begin
          PCWrite      = 1'b1;
          w_timeout    = 1'b1;
          w_next_state = RUN;
        end
`endif
      end
      default: w_next_state = RUN;
    endcase
    if (reset) begin
      RegWrite  = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      w_flag_wr = 1'b0;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_flags <= 4'b0000;
    end else begin
      r_state <= w_next_state;
      if (w_flag_wr) r_flags <= ALUFlags;
    end
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  // Counter holds the index of the current MEMWAIT cycle (0..15)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= 4'h0;
      r_mem_err <= 1'b0;
    end else begin
      if (r_state == MEMWAIT && w_next_state == MEMWAIT) r_tmo_cnt <= r_tmo_cnt + 4'h1;
      else r_tmo_cnt <= 4'h0;
      if (w_timeout) r_mem_err <= 1'b1;
    end
  end
  assign MemErr = r_mem_err;
`else
  assign MemErr = 1'b0;
`endif

endmodule

`default_nettype wire
